// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage.
//   VEC_*      : PC values loaded on reset / interrupt / exception entry
//   INSTR_NOP  : bubble instruction word placed in IF/ID on flush and reset
//   REG_K0     : register that receives the exception return address
//   sel_t      : next-PC source select
package fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [XLEN-1:0]  VEC_RESET = 32'h8000_0000;
  localparam logic [XLEN-1:0]  VEC_IRQ   = 32'h8000_0004;
  localparam logic [XLEN-1:0]  VEC_EXC   = 32'h8000_0008;
  localparam logic [XLEN-1:0]  INSTR_NOP = 32'h0000_0000;
  localparam logic [REG_W-1:0] REG_K0    = 5'd26;

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_IRQ   = 3'd2,
    SEL_EXC   = 3'd3,
    SEL_HOLD  = 3'd4
  } sel_t;

endpackage

// File: rtl/fetch_irq_sync.sv
// Two-flop synchroniser for the asynchronous interrupt level.
// Used by instruction_fetch only when FETCH_IRQ_SYNC_EN is defined.
// Ports:
//   clk       in  1  clock
//   reset     in  1  synchronous active-low reset, clears both flops
//   irq_in    in  1  raw interrupt level
//   irq_sync  out 1  interrupt level after two clk stages
module fetch_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic irq_sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta     <= 1'b0;
      irq_sync <= 1'b0;
    end else begin
      meta     <= irq_in;
      irq_sync <= meta;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Program counter and IF/ID register in front of the instruction ROM.
// Next PC is chosen from exception, interrupt, redirect, stall-hold or
// sequential sources; PC[31] is the supervisor bit.
// Config macro: FETCH_IRQ_SYNC_EN (irq passes a two-flop synchroniser).
// Ports:
//   clk, reset (sync, active-low)
//   stall, redir_valid/redir_pc, exc_valid/exc_pc, irq   : control inputs
//   rom_addr (= pc), rom_data                            : ROM interface
//   id_instr, id_pc, id_pc4, id_valid                    : IF/ID register
//   epc_we, epc                                          : $k0 write-back
import fetch_pkg::*;

module instruction_fetch #(
  parameter logic [31:0] RESET_VEC = VEC_RESET,
  parameter logic [31:0] IRQ_VEC   = VEC_IRQ,
  parameter logic [31:0] EXC_VEC   = VEC_EXC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        irq,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        epc_we,
  output logic [31:0] epc
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_nxt;
  logic            irq_s;
  logic            irq_take;
  sel_t            sel;

`ifdef FETCH_IRQ_SYNC_EN
  fetch_irq_sync u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq),
    .irq_sync (irq_s)
  );
`else
  assign irq_s = irq;
`endif

  assign rom_addr = pc;
  assign pc_plus4 = pc + 32'd4;

  // Interrupts only in user mode, and deferred behind stall/redirect/exception.
  assign irq_take = irq_s & ~pc[31] & ~redir_valid & ~stall & ~exc_valid;

  // Next-PC source priority.
  always_comb begin
    sel = SEL_SEQ;
    if (exc_valid)        sel = SEL_EXC;
    else if (irq_take)    sel = SEL_IRQ;
    else if (redir_valid) sel = SEL_REDIR;
    else if (stall)       sel = SEL_HOLD;
  end

  // Redirect may drop the supervisor bit but never raise it.
  always_comb begin
    pc_nxt = pc_plus4;
    case (sel)
      SEL_EXC:   pc_nxt = EXC_VEC;
      SEL_IRQ:   pc_nxt = IRQ_VEC;
      SEL_REDIR: pc_nxt = {pc[31] & redir_pc[31], redir_pc[30:0]};
      SEL_HOLD:  pc_nxt = pc;
      default:   pc_nxt = pc_plus4;
    endcase
  end

  // PC, IF/ID and EPC registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_VEC;
      id_instr <= INSTR_NOP;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
      epc_we   <= 1'b0;
      epc      <= '0;
    end else begin
      pc     <= pc_nxt;
      epc_we <= 1'b0;
      case (sel)
        SEL_EXC: begin
          epc      <= exc_pc + 32'd4;
          epc_we   <= 1'b1;
          id_instr <= INSTR_NOP;
          id_valid <= 1'b0;
        end
        SEL_IRQ: begin
          epc      <= pc;
          epc_we   <= 1'b1;
          id_instr <= INSTR_NOP;
          id_valid <= 1'b0;
        end
        SEL_REDIR: begin
          id_instr <= INSTR_NOP;
          id_valid <= 1'b0;
        end
        SEL_HOLD: ;
        default: begin
          id_instr <= rom_data;
          id_pc    <= pc;
          id_pc4   <= pc_plus4;
          id_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch with a behavioural reference model,
// plus directed scenarios pinned with literal expectations.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        irq;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        epc_we;
  logic [31:0] epc;

  logic [31:0] rom [64];

  int n_chk;
  int n_fail;
  bit chk_en;

  // reference model state
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_epc;
  logic        m_valid, m_we;
  logic [1:0]  m_hist;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .exc_valid   (exc_valid),
    .exc_pc      (exc_pc),
    .irq         (irq),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .epc_we      (epc_we),
    .epc         (epc)
  );

  assign rom_data = rom[rom_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one clock edge worth of architectural behaviour.
  task automatic model_edge(input logic rst, input logic st, input logic rv,
                            input logic [31:0] rp, input logic ev,
                            input logic [31:0] ep, input logic iq);
    logic irq_seen;
    if (!rst) begin
      m_pc = 32'h8000_0000; m_instr = 0; m_idpc = 0; m_idpc4 = 0;
      m_valid = 0; m_we = 0; m_epc = 0; m_hist = 0;
      return;
    end
`ifdef FETCH_IRQ_SYNC_EN
    irq_seen = m_hist[1];
    m_hist   = {m_hist[0], iq};
`else
    irq_seen = iq;
`endif
    m_we = 0;
    if (ev) begin
      m_epc = ep + 4; m_we = 1; m_pc = 32'h8000_0008;
      m_instr = 0; m_valid = 0;
    end else if (irq_seen && m_pc < 32'h8000_0000 && !rv && !st) begin
      m_epc = m_pc; m_we = 1; m_pc = 32'h8000_0004;
      m_instr = 0; m_valid = 0;
    end else if (rv) begin
      // user mode may only land in user space
      m_pc = (m_pc >= 32'h8000_0000) ? rp : (rp % 32'h8000_0000);
      m_instr = 0; m_valid = 0;
    end else if (!st) begin
      m_instr = rom[m_pc[7:2]]; m_idpc = m_pc; m_idpc4 = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4;
    end
  endtask

  // Apply inputs for one cycle; return #2 after the edge.
  task automatic cyc(input logic rst, input logic st, input logic rv,
                     input logic [31:0] rp, input logic ev,
                     input logic [31:0] ep, input logic iq);
    reset = rst; stall = st; redir_valid = rv; redir_pc = rp;
    exc_valid = ev; exc_pc = ep; irq = iq;
    @(posedge clk);
    model_edge(rst, st, rv, rp, ev, ep, iq);
    #2;
    chk_en = 1'b1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rom_addr", rom_addr, m_pc);
      chk("id_instr", id_instr, m_instr);
      chk("id_pc",    id_pc,    m_idpc);
      chk("id_pc4",   id_pc4,   m_idpc4);
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("epc_we",   32'(epc_we),   32'(m_we));
      chk("epc",      epc,      m_epc);
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    reset = 1'b0; stall = 0; redir_valid = 0; redir_pc = 0;
    exc_valid = 0; exc_pc = 0; irq = 0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;

    // reset state
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_pc",       rom_addr, 32'h8000_0000);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc",    id_pc,    32'h0);
    chk("rst_epc",      epc,      32'h0);
    chk("rst_epc_we",   32'(epc_we), 32'h0);

    // sequential fetch after release
    idle();
    chk("seq_pc1",    rom_addr, 32'h8000_0004);
    chk("seq_idpc1",  id_pc,    32'h8000_0000);
    chk("seq_idpc4",  id_pc4,   32'h8000_0004);
    chk("seq_valid1", 32'(id_valid), 32'h1);
    chk("seq_instr1", id_instr, rom[0]);
    idle();
    chk("seq_pc2",    rom_addr, 32'h8000_0008);
    chk("seq_idpc2",  id_pc,    32'h8000_0004);

    // redirects: kernel keeps bit from target, then drops to user
    cyc(1, 0, 1, 32'h8000_00B0, 0, 0, 0);
    chk("redir_k",       rom_addr, 32'h8000_00B0);
    chk("redir_flush",   32'(id_valid), 32'h0);
    cyc(1, 0, 1, 32'h0000_002C, 0, 0, 0);
    chk("redir_user",    rom_addr, 32'h0000_002C);
    chk("flush_keep_pc", id_pc,    32'h8000_0004);
    idle();
    chk("after_redir_pc",    rom_addr, 32'h0000_0030);
    chk("after_redir_idpc",  id_pc,    32'h0000_002C);
    chk("after_redir_instr", id_instr, rom[11]);

`ifndef FETCH_IRQ_SYNC_EN
    // user-mode interrupt, then irq ignored in kernel
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("irq_pc",    rom_addr, 32'h8000_0004);
    chk("irq_epc",   epc,      32'h0000_0030);
    chk("irq_we",    32'(epc_we), 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("irq_kern_pc", rom_addr, 32'h8000_0008);
    chk("irq_kern_we", 32'(epc_we), 32'h0);
`endif

    // kernel jr to user, then user cannot set supervisor bit
    cyc(1, 0, 1, 32'h0000_0054, 0, 0, 0);
    chk("jr_user", rom_addr, 32'h0000_0054);
    cyc(1, 0, 1, 32'h8000_0010, 0, 0, 0);
    chk("no_set_k", rom_addr, 32'h0000_0010);

    cyc(1, 0, 1, 32'h0000_0150, 0, 0, 0);
    chk("user_150", rom_addr, 32'h0000_0150);
`ifndef FETCH_IRQ_SYNC_EN
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("irq2_pc",  rom_addr, 32'h8000_0004);
    chk("irq2_epc", epc,      32'h0000_0150);
    chk("irq2_we",  32'(epc_we), 32'h1);
    idle();
    chk("irq2_we_pulse", 32'(epc_we), 32'h0);
`endif

    // exception beats irq and stall
    cyc(1, 1, 0, 0, 1, 32'h0000_0160, 1);
    chk("exc_pc",    rom_addr, 32'h8000_0008);
    chk("exc_epc",   epc,      32'h0000_0164);
    chk("exc_we",    32'(epc_we), 32'h1);
    chk("exc_valid", 32'(id_valid), 32'h0);
    chk("exc_instr", id_instr, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("post_exc_pc", rom_addr, 32'h8000_000C);
    chk("post_exc_we", 32'(epc_we), 32'h0);

    // stall holds everything; reset during stall wins
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("stall_pc",    rom_addr, 32'h8000_000C);
      chk("stall_idpc",  id_pc,    32'h8000_0008);
      chk("stall_instr", id_instr, rom[2]);
      chk("stall_valid", 32'(id_valid), 32'h1);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst_stall_pc",    rom_addr, 32'h8000_0000);
    chk("rst_stall_valid", 32'(id_valid), 32'h0);

    // randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic        r_rst, r_st, r_rv, r_ev, r_iq;
      logic [31:0] r_rp, r_ep;
      r_rst = ($urandom_range(0, 99) != 0);
      r_st  = ($urandom_range(0, 99) < 20);
      r_rv  = ($urandom_range(0, 99) < 10);
      r_ev  = ($urandom_range(0, 99) < 4);
      r_iq  = ($urandom_range(0, 99) < 30);
      r_rp  = $urandom & 32'hFFFF_FFFC;
      r_ep  = $urandom & 32'hFFFF_FFFC;
      cyc(r_rst, r_st, r_rv, r_rp, r_ev, r_ep, r_iq);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
